hazard_scoreboard: RTL and testbench

- Consumer end of the ID/EX hazard bundle: ifReGrf1/2, grfRa1/2, ifWrGrf, grfWa, tUseRs/Rt, tNew.
- Keeps shadow EX, MEM and WB entries that advance in lock-step with the pipeline registers.
- Ages each entry's tNew every cycle and decides stall and forward selects for the ID, EX and MEM stages.
- Datapath muxes live outside; this block drives only control.

---
 rtl/hazard_scoreboard.sv | 188 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Consumer end of the ID/EX hazard bundle. Tracks shadow copies of the EX, MEM
// and WB pipeline entries (destination, remaining tNew, source addresses) and
// derives the stall and operand-forward selects for the ID, EX and MEM stages.
// The datapath muxes live elsewhere; this block only produces control.
//
// Ports:
//   clk, reset        pipeline clock, synchronous active-high reset
//   ifReGrf1/2_Id     ID instruction reads rs / rt
//   grfRa1/2_Id       rs / rt addresses in ID
//   tUseRs/Rt_Id      cycles from ID until rs / rt is consumed
//   ifWrGrf_Id        ID instruction writes the GRF
//   grfWa_Id          destination register of the ID instruction
//   tNew_Id           cycles after entering EX until the result is ready
//   stall             freeze PC and IF/ID, bubble ID/EX
//   fwdRs_Id/fwdRt_Id ID operand source: 0 GRF, 1 EX, 2 MEM, 3 WB
//   fwdAluA/B_Ex      EX operand source: 0 ID/EX value, 2 MEM, 3 WB
//   fwdRt_Mem         MEM store-data source: 0 EX/MEM value, 3 WB
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int TNEW_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReGrf1_Id,
  input  logic              ifReGrf2_Id,
  input  logic [4:0]        grfRa1_Id,
  input  logic [4:0]        grfRa2_Id,
  input  logic [TNEW_W-1:0] tUseRs_Id,
  input  logic [TNEW_W-1:0] tUseRt_Id,
  input  logic              ifWrGrf_Id,
  input  logic [4:0]        grfWa_Id,
  input  logic [TNEW_W-1:0] tNew_Id,
  output logic              stall,
  output logic [1:0]        fwdRs_Id,
  output logic [1:0]        fwdRt_Id,
  output logic [1:0]        fwdAluA_Ex,
  output logic [1:0]        fwdAluB_Ex,
  output logic [1:0]        fwdRt_Mem
);

  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic              wr;
    logic [4:0]        wa;
    logic [TNEW_W-1:0] tnew;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic              re1;
    logic              re2;
  } entry_t;

  localparam logic [TNEW_W-1:0] TNEW_ONE = {{(TNEW_W-1){1'b0}}, 1'b1};

  // Shadow pipeline entries
  entry_t r_e, r_m, r_w;
  entry_t w_id;

  // A writer to $0 never produces a hazard, so it is filtered here once.
  function automatic logic hits(input entry_t x, input logic [4:0] a);
    return x.wr && (x.wa != 5'd0) && (x.wa == a);
  endfunction

  function automatic logic ready(input entry_t x);
    return x.tnew == '0;
  endfunction

  // Moving one stage down the pipe costs one cycle of remaining latency.
  function automatic entry_t age(input entry_t x);
    entry_t y;
    y = x;
    if (x.tnew != '0) y.tnew = x.tnew - TNEW_ONE;
    return y;
  endfunction

  always_comb begin
    w_id      = '0;
    w_id.wr   = ifWrGrf_Id;
    w_id.wa   = grfWa_Id;
    w_id.tnew = tNew_Id;
    w_id.ra1  = grfRa1_Id;
    w_id.ra2  = grfRa2_Id;
    w_id.re1  = ifReGrf1_Id;
    w_id.re2  = ifReGrf2_Id;
  end

  // ---------------------------------------------------------------------------
  // ID stage: stall and forward per source operand
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0]             w_id_re;
  logic [NUM_SRC-1:0][4:0]        w_id_ra;
  logic [NUM_SRC-1:0][TNEW_W-1:0] w_id_tuse;
  logic [NUM_SRC-1:0]             w_id_stall;
  logic [NUM_SRC-1:0][1:0]        w_id_fwd;

  assign w_id_re   = {ifReGrf2_Id, ifReGrf1_Id};
  assign w_id_ra   = {grfRa2_Id, grfRa1_Id};
  assign w_id_tuse = {tUseRt_Id, tUseRs_Id};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_id
    logic       l_stall;
    logic [1:0] l_fwd;

    // Only the youngest matching writer counts; an older one never serves as
    // a fallback, since its value is stale once a younger write exists.
    always_comb begin
      l_stall = 1'b0;
      l_fwd   = 2'd0;
      if (w_id_re[g] && (w_id_ra[g] != 5'd0)) begin
        if (hits(r_e, w_id_ra[g])) begin
          l_stall = r_e.tnew > w_id_tuse[g];
          l_fwd   = ready(r_e) ? 2'd1 : 2'd0;
        end else if (hits(r_m, w_id_ra[g])) begin
          l_stall = r_m.tnew > w_id_tuse[g];
          l_fwd   = ready(r_m) ? 2'd2 : 2'd0;
        end else if (hits(r_w, w_id_ra[g])) begin
          l_stall = r_w.tnew > w_id_tuse[g];
          l_fwd   = ready(r_w) ? 2'd3 : 2'd0;
        end
      end
    end

    assign w_id_stall[g] = l_stall;
    assign w_id_fwd[g]   = l_fwd;
  end

  assign stall    = |w_id_stall;
  assign fwdRs_Id = w_id_fwd[0];
  assign fwdRt_Id = w_id_fwd[1];

  // ---------------------------------------------------------------------------
  // EX stage: the instruction now in E looks back at M and W
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0]      w_ex_re;
  logic [NUM_SRC-1:0][4:0] w_ex_ra;
  logic [NUM_SRC-1:0][1:0] w_ex_fwd;

  assign w_ex_re = {r_e.re2, r_e.re1};
  assign w_ex_ra = {r_e.ra2, r_e.ra1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ex
    logic [1:0] l_fwd;

    always_comb begin
      l_fwd = 2'd0;
      if (w_ex_re[g] && (w_ex_ra[g] != 5'd0)) begin
        if (hits(r_m, w_ex_ra[g]))      l_fwd = ready(r_m) ? 2'd2 : 2'd0;
        else if (hits(r_w, w_ex_ra[g])) l_fwd = ready(r_w) ? 2'd3 : 2'd0;
      end
    end

    assign w_ex_fwd[g] = l_fwd;
  end

  assign fwdAluA_Ex = w_ex_fwd[0];
  assign fwdAluB_Ex = w_ex_fwd[1];

  // ---------------------------------------------------------------------------
  // MEM stage: store data may come from the writer in W
  // ---------------------------------------------------------------------------
  logic w_mem_hit;
  assign w_mem_hit = r_m.re2 && (r_m.ra2 != 5'd0) && hits(r_w, r_m.ra2) && ready(r_w);
  assign fwdRt_Mem = w_mem_hit ? 2'd3 : 2'd0;

  // Source fields of the older entries are kept for completeness of the
  // shadow copy but are not looked at by any stage.
  logic w_unused;
  assign w_unused = ^{r_m.ra1, r_m.re1, r_w.ra1, r_w.ra2, r_w.re1, r_w.re2};

  // ---------------------------------------------------------------------------
  // Lock-step advance. M and W always move; E takes a bubble while stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= stall ? '0 : w_id;
      r_m <= age(r_e);
      r_w <= age(r_m);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench. The reference model keeps a list of in-flight
// instructions stamped with the cycle they entered EX; stage and remaining
// latency are derived from the current cycle number.
module tb_hazard_scoreboard;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ifReGrf1_Id, ifReGrf2_Id, ifWrGrf_Id;
  logic [4:0]    grfRa1_Id, grfRa2_Id, grfWa_Id;
  logic [TW-1:0] tUseRs_Id, tUseRt_Id, tNew_Id;
  logic          stall;
  logic [1:0]    fwdRs_Id, fwdRt_Id, fwdAluA_Ex, fwdAluB_Ex, fwdRt_Mem;

  always #5 clk = ~clk;

  hazard_scoreboard #(.TNEW_W(TW)) dut (
    .clk(clk), .reset(reset),
    .ifReGrf1_Id(ifReGrf1_Id), .ifReGrf2_Id(ifReGrf2_Id),
    .grfRa1_Id(grfRa1_Id), .grfRa2_Id(grfRa2_Id),
    .tUseRs_Id(tUseRs_Id), .tUseRt_Id(tUseRt_Id),
    .ifWrGrf_Id(ifWrGrf_Id), .grfWa_Id(grfWa_Id), .tNew_Id(tNew_Id),
    .stall(stall), .fwdRs_Id(fwdRs_Id), .fwdRt_Id(fwdRt_Id),
    .fwdAluA_Ex(fwdAluA_Ex), .fwdAluB_Ex(fwdAluB_Ex), .fwdRt_Mem(fwdRt_Mem)
  );

  typedef struct { bit rd1, rd2, wr; int a1, a2, tu1, tu2, wa, tn; } ins_t;
  typedef struct { ins_t i; int enter; } fl_t;
  typedef struct { bit st; int rs, rt, aa, ab, rm, cyc; } exp_t;

  fl_t  fl[$];
  exp_t sbq[$];
  int   ncyc = 0;
  int   n_cmp = 0, n_bad = 0;

  function automatic ins_t mk(bit rd1, int a1, int tu1, bit rd2, int a2, int tu2,
                              bit wr, int wa, int tn);
    ins_t c;
    c.rd1 = rd1; c.a1 = a1; c.tu1 = tu1;
    c.rd2 = rd2; c.a2 = a2; c.tu2 = tu2;
    c.wr = wr; c.wa = wa; c.tn = tn;
    return c;
  endfunction

  // Instruction sitting k stages past EX entry (0=E, 1=M, 2=W) this cycle.
  function automatic bit at_stage(int k, output ins_t o);
    bit f = 0;
    o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (fl[j]) if (fl[j].enter == ncyc - k) begin o = fl[j].i; f = 1; end
    return f;
  endfunction

  function automatic int rem(ins_t o, int k);
    return (o.tn - k > 0) ? o.tn - k : 0;
  endfunction

  function automatic bit writes(ins_t o, int a);
    return o.wr && o.wa != 0 && o.wa == a;
  endfunction

  function automatic void id_src(bit re, int a, int tu, output bit st, output int f);
    ins_t o;
    st = 0; f = 0;
    if (!re || a == 0) return;
    for (int k = 0; k < 3; k++)
      if (at_stage(k, o) && writes(o, a)) begin
        st = rem(o, k) > tu;
        f  = (rem(o, k) == 0) ? k + 1 : 0;
        return;
      end
  endfunction

  function automatic int ex_src(bit re, int a);
    ins_t o;
    if (!re || a == 0) return 0;
    for (int k = 1; k < 3; k++)
      if (at_stage(k, o) && writes(o, a)) return (rem(o, k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic exp_t model(ins_t c);
    exp_t e;
    ins_t x, w;
    bit   s1, s2;
    int   f1, f2;
    id_src(c.rd1, c.a1, c.tu1, s1, f1);
    id_src(c.rd2, c.a2, c.tu2, s2, f2);
    e.st = s1 | s2; e.rs = f1; e.rt = f2;
    e.aa = 0; e.ab = 0; e.rm = 0; e.cyc = ncyc;
    if (at_stage(0, x)) begin
      e.aa = ex_src(x.rd1, x.a1);
      e.ab = ex_src(x.rd2, x.a2);
    end
    if (at_stage(1, x) && x.rd2 && at_stage(2, w) && writes(w, x.a2) && rem(w, 2) == 0)
      e.rm = 3;
    return e;
  endfunction

  // One clock: drive, predict, push, advance the model across the edge.
  task automatic cyc(ins_t c, bit rst, output bit st);
    exp_t e;
    reset = rst;
    ifReGrf1_Id = c.rd1; grfRa1_Id = 5'(c.a1); tUseRs_Id = TW'(c.tu1);
    ifReGrf2_Id = c.rd2; grfRa2_Id = 5'(c.a2); tUseRt_Id = TW'(c.tu2);
    ifWrGrf_Id = c.wr;   grfWa_Id = 5'(c.wa);  tNew_Id = TW'(c.tn);
    e = model(c);
    sbq.push_back(e);
    st = e.st;
    @(posedge clk);
    if (rst) fl.delete();
    else if (!e.st) fl.push_back('{i: c, enter: ncyc + 1});
    ncyc++;
    while (fl.size() > 0 && fl[0].enter < ncyc - 2) void'(fl.pop_front());
    #1;
  endtask

  // Hold the instruction in ID until it is no longer stalled.
  task automatic issue(ins_t c);
    bit st;
    int n = 0;
    do begin cyc(c, 0, st); n++; end while (st && n < 8);
  endtask

  task automatic chk(string nm, logic [1:0] act, int exp, int cy);
    n_cmp++;
    if (act !== 2'(exp)) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cy, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("stall",      {1'b0, stall}, int'(e.st), e.cyc);
      chk("fwdRs_Id",   fwdRs_Id,   e.rs, e.cyc);
      chk("fwdRt_Id",   fwdRt_Id,   e.rt, e.cyc);
      chk("fwdAluA_Ex", fwdAluA_Ex, e.aa, e.cyc);
      chk("fwdAluB_Ex", fwdAluB_Ex, e.ab, e.cyc);
      chk("fwdRt_Mem",  fwdRt_Mem,  e.rm, e.cyc);
    end
  end

  initial begin
    ins_t nop, rd;
    bit   st;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    ifReGrf1_Id = 0; ifReGrf2_Id = 0; ifWrGrf_Id = 0;
    grfRa1_Id = 0; grfRa2_Id = 0; grfWa_Id = 0;
    tUseRs_Id = 0; tUseRt_Id = 0; tNew_Id = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then lw $1 / addu $2,$1,$1
    repeat (2) cyc(nop, 0, st);
    issue(mk(0, 0, 0, 0, 0, 0, 1, 1, 2));
    issue(mk(1, 1, 1, 1, 1, 1, 1, 2, 1));
    repeat (3) issue(nop);
    // addu $3 / beq $3,$0
    issue(mk(1, 0, 1, 1, 0, 1, 1, 3, 1));
    issue(mk(1, 3, 0, 1, 0, 0, 0, 0, 0));
    repeat (3) issue(nop);
    // lui $4 / addu $5,$4,$4
    issue(mk(0, 0, 0, 0, 0, 0, 1, 4, 0));
    issue(mk(1, 4, 1, 1, 4, 1, 1, 5, 1));
    repeat (3) issue(nop);
    // two writes to $6, then a read
    issue(mk(0, 0, 0, 0, 0, 0, 1, 6, 1));
    issue(mk(0, 0, 0, 0, 0, 0, 1, 6, 0));
    issue(mk(1, 6, 1, 1, 6, 1, 0, 0, 0));
    repeat (3) issue(nop);
    // write to $0 then read $0
    issue(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    issue(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    repeat (3) issue(nop);
    // reset while stalled
    issue(mk(0, 0, 0, 0, 0, 0, 1, 7, 3));
    rd = mk(1, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc(rd, 0, st);
    cyc(rd, 1, st);
    cyc(rd, 0, st);
    repeat (2) issue(nop);

    // randomized traffic on a small register set so hazards are frequent
    for (int n = 0; n < 500; n++) begin
      ins_t c;
      c = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2),
             ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) cyc(c, 1, st);
      else issue(c);
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
